// File: rtl/seg7_display_arbiter_if.sv
// Request/grant and shift-driver bundle between the two display requesters,
// the arbiter, and the serial 7-segment driver.
interface seg7_display_arbiter_if;
    logic        req0;
    logic        req1;
    logic [31:0] data0;
    logic [31:0] data1;
    logic        gnt0;
    logic        gnt1;
    logic [31:0] hexs;
    logic        start;
    logic        busy;
    logic        owner;

    modport master (
        output req0, req1, data0, data1,
        input  gnt0, gnt1, hexs, start, busy, owner
    );

    modport slave (
        input  req0, req1, data0, data1,
        output gnt0, gnt1, hexs, start, busy, owner
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin sequencer sharing the 32-bit serial hex display between two requesters.
// Define SEG7_REFRESH_EN to retransmit an unchanged frame after REFRESH idle cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | first cycle out of reset; sends the blank frame
// S_IDLE  | arbitrating; grants a requester or (optionally) refreshes
// S_SHIFT | driver is shifting the frame out, SHIFT_CYCLES long
// S_DWELL | frame held on display before re-arbitration, DWELL long
module seg7_display_arbiter #(
    parameter int unsigned SHIFT_CYCLES = 140,
    parameter int unsigned DWELL        = 1000,
    parameter int unsigned REFRESH      = 50000
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    seg7_display_arbiter_if.slave  bus
);

    generate
        if (SHIFT_CYCLES < 1 || SHIFT_CYCLES > 65535) begin : g_bad_shift
            $error("SHIFT_CYCLES must be in 1..65535");
        end
        if (DWELL > 65535) begin : g_bad_dwell
            $error("DWELL must be in 0..65535");
        end
        if (REFRESH < 1 || REFRESH > 65535) begin : g_bad_refresh
            $error("REFRESH must be in 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_IDLE  = 2'd1,
        S_SHIFT = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    localparam logic [15:0] SHIFT_LOAD = 16'(SHIFT_CYCLES - 1);
    localparam logic [15:0] DWELL_LOAD = 16'((DWELL == 0) ? 0 : DWELL - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] hexs_q, hexs_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        any_req;
    logic        win;
    logic        refresh_fire;

    assign any_req = bus.req0 | bus.req1;
    // Lone requester wins; on a tie the priority pointer decides.
    assign win     = bus.req1 & ~(bus.req0 & ~prio_q);

`ifdef SEG7_REFRESH_EN
    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH - 1);

    logic [15:0] refresh_q, refresh_d;

    assign refresh_fire = (state_q == S_IDLE) && !any_req && (refresh_q == REFRESH_LAST);

    always_comb begin
        refresh_d = refresh_q;
        if (state_q == S_IDLE) begin
            if (any_req || refresh_fire) begin
                refresh_d = '0;
            end else begin
                refresh_d = refresh_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    assign refresh_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hexs_d  = hexs_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        start_d = 1'b0;

        case (state_q)
            S_BOOT: begin
                hexs_d  = '0;
                start_d = 1'b1;
                cnt_d   = SHIFT_LOAD;
                state_d = S_SHIFT;
            end
            S_IDLE: begin
                if (any_req) begin
                    hexs_d  = win ? bus.data1 : bus.data0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    start_d = 1'b1;
                    owner_d = win;
                    prio_d  = ~win;
                    cnt_d   = SHIFT_LOAD;
                    state_d = S_SHIFT;
                end else if (refresh_fire) begin
                    start_d = 1'b1;
                    cnt_d   = SHIFT_LOAD;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    if (DWELL == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = DWELL_LOAD;
                        state_d = S_DWELL;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DWELL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_BOOT;
            cnt_q   <= '0;
            hexs_q  <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hexs_q  <= hexs_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.hexs  = hexs_q;
    assign bus.start = start_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Scoreboard bench for seg7_display_arbiter: a cycle-arithmetic model predicts frame
// events into a queue; a monitor pops and checks whenever the DUT strobes start/gnt.
module tb_seg7_display_arbiter;
    localparam int S = 4;
    localparam int D = 2;
    localparam int R = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg7_display_arbiter_if bus ();

    seg7_display_arbiter #(
        .SHIFT_CYCLES(S),
        .DWELL       (D),
        .REFRESH     (R)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic        g0;
        logic        g1;
        logic [31:0] hexs;
        logic        owner;
    } ev_t;

    ev_t q[$];

    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          idle_at = 0;
    logic        exp_busy = 1'b1;
    bit          done    = 1'b0;
    bit          hold    = 1'b0;
    bit          rnd     = 1'b0;
    logic        m_prio  = 1'b0;
    logic        m_owner = 1'b0;
    logic [31:0] m_hexs  = '0;
    int          m_idle  = 0;
    int          gnt_cyc = -1;
    logic        gnt_who = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [31:0] cur_hexs;
        logic        cur_owner;
        ev_t         e;
        cur_hexs  = '0;
        cur_owner = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("queue_drained", 32'(q.size()), 32'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (!rstn) begin
                q.delete();
                cur_hexs  = '0;
                cur_owner = 1'b0;
                chk("rst_start", 32'(bus.start), 32'd0);
                chk("rst_gnt",   {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
                chk("rst_hexs",  bus.hexs, 32'd0);
                chk("rst_owner", 32'(bus.owner), 32'd0);
                chk("rst_busy",  32'(bus.busy), 32'd1);
            end else begin
                chk("busy", 32'(bus.busy), 32'(exp_busy));
                if (bus.start || bus.gnt0 || bus.gnt1) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_event @cycle %0d: got start=%0b gnt0=%0b gnt1=%0b, expected none",
                                 cyc, bus.start, bus.gnt0, bus.gnt1);
                    end else begin
                        e = q.pop_front();
                        chk("evt_cycle", cyc, e.cyc);
                        chk("evt_start", 32'(bus.start), 32'd1);
                        chk("evt_gnt0",  32'(bus.gnt0), 32'(e.g0));
                        chk("evt_gnt1",  32'(bus.gnt1), 32'(e.g1));
                        chk("evt_hexs",  bus.hexs, e.hexs);
                        chk("evt_owner", 32'(bus.owner), 32'(e.owner));
                        cur_hexs  = e.hexs;
                        cur_owner = e.owner;
                    end
                end else begin
                    if (q.size() != 0 && q[0].cyc <= cyc) begin
                        e = q.pop_front();
                        n_cmp++;
                        n_bad++;
                        $display("FAIL missed_event @cycle %0d: got no start, expected start at cycle %0d",
                                 cyc, e.cyc);
                        cur_hexs  = e.hexs;
                        cur_owner = e.owner;
                    end
                    chk("hexs_hold",  bus.hexs, cur_hexs);
                    chk("owner_hold", 32'(bus.owner), 32'(cur_owner));
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // The display is free again SHIFT+DWELL cycles after each start; a request seen
    // in a free cycle is granted at the following edge.
    task automatic eval();
        logic w;
        exp_busy = (cyc < idle_at);
        if (cyc >= idle_at) begin
            if (bus.req0 || bus.req1) begin
                ev_t e;
                w        = (bus.req0 && bus.req1) ? m_prio : bus.req1;
                m_hexs   = w ? bus.data1 : bus.data0;
                m_owner  = w;
                m_prio   = !w;
                m_idle   = 0;
                e.cyc    = cyc + 1;
                e.g0     = !w;
                e.g1     = w;
                e.hexs   = m_hexs;
                e.owner  = w;
                q.push_back(e);
                idle_at  = cyc + 1 + S + D;
                gnt_cyc  = cyc + 1;
                gnt_who  = w;
            end else begin
`ifdef SEG7_REFRESH_EN
                m_idle++;
                if (m_idle == R) begin
                    ev_t e;
                    m_idle  = 0;
                    e.cyc   = cyc + 1;
                    e.g0    = 1'b0;
                    e.g1    = 1'b0;
                    e.hexs  = m_hexs;
                    e.owner = m_owner;
                    q.push_back(e);
                    idle_at = cyc + 1 + S + D;
                end
`endif
            end
        end
    endtask

    task automatic release_rst();
        ev_t e;
        rstn    = 1'b1;
        cyc     = 0;
        idle_at = 1 + S + D;
        m_prio  = 1'b0;
        m_owner = 1'b0;
        m_hexs  = '0;
        m_idle  = 0;
        gnt_cyc = -1;
        exp_busy = 1'b1;
        e.cyc   = 1;
        e.g0    = 1'b0;
        e.g1    = 1'b0;
        e.hexs  = '0;
        e.owner = 1'b0;
        q.push_back(e);
    endtask

    // Advance one cycle and apply automatic requester behaviour; directed code may
    // then adjust inputs before eval() snapshots them for the model.
    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        if (!hold && gnt_cyc == cyc) begin
            if (gnt_who) bus.req1 = 1'b0;
            else         bus.req0 = 1'b0;
        end
        if (rnd) begin
            if (!bus.req0) begin
                if ($urandom_range(3) == 0) begin
                    bus.data0 = $urandom;
                    bus.req0  = 1'b1;
                end
            end else if ($urandom_range(31) == 0) begin
                bus.req0 = 1'b0;
            end
            if (!bus.req1) begin
                if ($urandom_range(3) == 0) begin
                    bus.data1 = $urandom;
                    bus.req1  = 1'b1;
                end
            end else if ($urandom_range(31) == 0) begin
                bus.req1 = 1'b0;
            end
        end
    endtask

    task automatic step();
        adv();
        eval();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (cyc + 1 < idle_at); i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
        repeat (3) @(negedge clk);
        #1;
        release_rst();

        // boot frame, then idle (refresh pulses when enabled)
        run(50);

        // single requester
        wait_idle();
        adv();
        bus.data0 = 32'h1234_ABCD;
        bus.req0  = 1'b1;
        eval();
        run(10);

        // both held: alternating grants at the frame period
        wait_idle();
        adv();
        hold      = 1'b1;
        bus.data1 = 32'hDEAD_BEEF;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        eval();
        run(30);
        adv();
        hold     = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        eval();

        // req1 rising in SHIFT cycle 2 waits for the first IDLE cycle
        wait_idle();
        adv();
        bus.data0 = $urandom;
        bus.req0  = 1'b1;
        eval();
        step();
        adv();
        bus.data1 = $urandom;
        bus.req1  = 1'b1;
        eval();
        run(12);

        // randomized traffic, including drops before grant
        rnd = 1'b1;
        run(400);
        rnd = 1'b0;
        adv();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        eval();

        // reset in SHIFT cycle 3 with the request held through it
        wait_idle();
        adv();
        hold      = 1'b1;
        bus.data0 = $urandom;
        bus.req0  = 1'b1;
        eval();
        step();
        step();
        adv();
        eval();
        #1;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        release_rst();
        run(10);
        adv();
        hold     = 1'b0;
        bus.req0 = 1'b0;
        eval();
        run(10);

        done = 1'b1;
    end
endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Sequencer and arbiter for the serial 7-segment display shifter. Shares the single 32-bit hex display between two requesters (game logic, debug/score) under round-robin with a minimum dwell. Generates the one-cycle `start` strobe and the `hexs` frame for the shift driver. Models the driver's shift time with a counter, because the driver has no done output.

## Interface

Parameters:
- `SHIFT_CYCLES`, default 140: clk cycles one serial frame occupies the driver; legal range 1..65535.
- `DWELL`, default 1000: minimum cycles a frame stays displayed after shifting before re-arbitration; legal range 0..65535.
- `REFRESH`, default 50000: idle cycles before an unchanged frame is retransmitted; legal range 1..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1 each: level request; held until the matching grant.
- `data0`, `data1` in 32 each: frame to display; must be stable while the matching req is high.
- `gnt0`, `gnt1` out 1 each: one-cycle grant; data was captured at this edge.
- `hexs` out 32: frame presented to the shift driver.
- `start` out 1: one-cycle strobe to the driver's Start input.
- `busy` out 1: high whenever state ≠ IDLE.
- `owner` out 1: index of the last granted requester.

## Operation

- States: BOOT, IDLE, SHIFT, DWELL. All outputs are registered.
- Reset (async, `rstn`=0): state BOOT; `hexs`=0, `start`=0, `gnt0`/`gnt1`=0, `busy`=1, `owner`=0. Priority pointer `prio`=0, so requester 0 wins the first tie. Shift, dwell and refresh counters = 0.
- BOOT: on the first edge with `rstn`=1, drive `start`=1 with `hexs`=0 (blank frame), no grant, and go to SHIFT. Pending requests wait.
- IDLE, arbitration:
  - If exactly one req is high, that requester wins.
  - If both are high, requester `prio` wins.
  - At the edge: `hexs`←winner's data, matching gnt=1, `start`=1, `owner`←winner, `prio`←~winner, shift counter←SHIFT_CYCLES−1, refresh counter cleared, go to SHIFT.
- SHIFT: `gnt`/`start` drop after one cycle. The state lasts exactly SHIFT_CYCLES cycles, counting down; at 0 go to DWELL with counter DWELL−1, or directly to IDLE if DWELL=0.
- DWELL: lasts exactly DWELL cycles; then go to IDLE. Requests are ignored (not granted) in SHIFT and DWELL.
- `hexs` changes only on a grant or on reset.
- Counters are 16-bit unsigned and never wrap: they load, then count down to 0.

## Timing

- Grant latency: a req first seen high in an IDLE cycle is granted at the next edge. `gnt`, `start` and the new `hexs` are all valid in the same cycle.
- A req that rises during SHIFT/DWELL is granted at the edge that ends the first IDLE cycle.
- Back-to-back frame period: 1 (IDLE) + SHIFT_CYCLES + DWELL cycles.
- Both requests held continuously: grants alternate 0,1,0,1 at that period.
- Requester drops req before its grant: no grant; if the other req is high it wins.
- Simultaneous refresh expiry and req: the grant wins; the refresh counter clears.
- `rstn` asserted mid-SHIFT/DWELL: outputs take reset values immediately. A grant in flight is withdrawn. Requesters keep req; a BOOT frame follows release.

## Configuration

- `SEG7_REFRESH_EN` defined:
  - The refresh counter increments in each IDLE cycle with no req.
  - When it reaches REFRESH, the next edge asserts `start`=1 with `hexs` unchanged and no gnt. The counter clears, the shift counter loads, and the state goes to SHIFT (then DWELL as usual).
- Undefined: no refresh counter; `start` occurs only on BOOT and on grants.

## Test plan

Parameters SHIFT_CYCLES=4, DWELL=2, REFRESH=16, no requests unless stated.

- Reset release -> `start`=1 and `hexs`=0 in cycle 1, no gnt. `busy` stays high for 4+2 cycles, then IDLE with `busy`=0.
- `req0`=1 with `data0`=32'h1234_ABCD in IDLE -> next cycle `gnt0`=1, `start`=1, `hexs`=32'h1234_ABCD, `owner`=0. `busy` high for 6 cycles.
- `req0` and `req1` held from IDLE (`data1`=32'hDEAD_BEEF) -> grants 0,1,0,1 every 7 cycles; `hexs` alternates to match.
- `req1` raised in SHIFT cycle 2 -> no grant until DWELL ends; `gnt1` at the edge after the first IDLE cycle.
- With `SEG7_REFRESH_EN`, idle after a frame -> `start` pulses after every 16 IDLE cycles, gnts stay 0, `hexs` unchanged. Without the macro -> no `start` pulses.
- `rstn` low in SHIFT cycle 3 -> `hexs`=0, `start`=0, gnts=0, `owner`=0 immediately. After release, a BOOT blank frame, then the held req is granted.
